// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types and constants for the core slice.
//   sleep_state_e : sleep controller FSM state encoding (2 bits).
//   SleepStatsW   : width of the sleep cycle statistics counter.
package cve2_pkg;

    typedef enum logic [1:0] {
        SleepRun      = 2'd0,
        SleepIdleWait = 2'd1,
        SleepSleep    = 2'd2,
        SleepWake     = 2'd3
    } sleep_state_e;

    localparam int unsigned SleepStatsW = 32;

endpackage

// File: rtl/prim_clock_gating.sv
// prim_clock_gating: latch-based integrated clock gate.
//   clk_i     : free-running clock
//   en_i      : functional enable
//   test_en_i : DFT override, forces the gate open
//   clk_o     : gated clock
module prim_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    // Transparent while clk_i is low so the enable cannot glitch clk_o.
    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = en_latch & clk_i;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: core sleep/wake controller with idle hysteresis,
// maskable and unmaskable wake sources, a minimum post-wake clock window
// and wake cause capture. Owns the core clock gate.
//   clk_i, rst_i   : free-running clock, synchronous active-high reset
//   test_en_i      : DFT clock gate override
//   busy_i         : core busy indication
//   wake_src_i     : raw wake requests, qualified by wake_mask_i
//   debug_req_i    : unmaskable debug wake
//   irq_nm_i       : unmaskable NMI wake
//   clk_o          : gated core clock
//   clock_en_o     : gate enable, core_sleep_o is its inverse
//   wake_cause_o   : {nmi, debug, masked srcs} captured on each wake
//   sleep_entry_o  : one-cycle pulse in the first SLEEP cycle
// Optional (CVE2_SLEEP_STATS_EN): sleep_cycles_o, sleep_count_o saturating
// statistics counters.
module cve2_sleep_ctrl
    import cve2_pkg::*;
#(
    parameter int unsigned NumWakeSrc = 18,
    parameter int unsigned IdleDelay  = 4,
    parameter int unsigned WakeHold   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic                  busy_i,
    input  logic [NumWakeSrc-1:0] wake_src_i,
    input  logic [NumWakeSrc-1:0] wake_mask_i,
    input  logic                  debug_req_i,
    input  logic                  irq_nm_i,
    output logic                  clk_o,
    output logic                  clock_en_o,
    output logic                  core_sleep_o,
    output logic [NumWakeSrc+1:0] wake_cause_o,
    output logic                  sleep_entry_o
`ifdef CVE2_SLEEP_STATS_EN
    ,
    output logic [SleepStatsW-1:0] sleep_cycles_o,
    output logic [15:0]            sleep_count_o
`endif
);

    localparam int unsigned IdleCntW = (IdleDelay > 0) ? $clog2(IdleDelay + 1) : 1;
    localparam int unsigned HoldCntW = (WakeHold > 1) ? $clog2(WakeHold) : 1;

    sleep_state_e          state_q, state_d;
    logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [HoldCntW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NumWakeSrc+1:0] cause_q, cause_d;
    logic                  sleep_entry_q, sleep_entry_d;
    logic [NumWakeSrc-1:0] wake_masked;
    logic                  wake_any;

    assign wake_masked = wake_src_i & wake_mask_i;
    assign wake_any    = (|wake_masked) | debug_req_i | irq_nm_i;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        unique case (state_q)
            SleepRun: begin
                if (!(busy_i || wake_any)) begin
                    if (IdleDelay == 0) begin
                        state_d = SleepSleep;
                    end else begin
                        state_d    = SleepIdleWait;
                        idle_cnt_d = IdleCntW'(IdleDelay - 1);
                    end
                end
            end
            SleepIdleWait: begin
                // Renewed activity wins over counter expiry.
                if (busy_i || wake_any) begin
                    state_d = SleepRun;
                end else if (idle_cnt_q == '0) begin
                    state_d = SleepSleep;
                end else begin
                    idle_cnt_d = idle_cnt_q - IdleCntW'(1);
                end
            end
            SleepSleep: begin
                if (wake_any) begin
                    state_d    = SleepWake;
                    cause_d    = {irq_nm_i, debug_req_i, wake_masked};
                    hold_cnt_d = HoldCntW'(WakeHold - 1);
                end
            end
            SleepWake: begin
                if (hold_cnt_q == '0) begin
                    state_d = SleepRun;
                end else begin
                    hold_cnt_d = hold_cnt_q - HoldCntW'(1);
                end
            end
            default: state_d = SleepRun;
        endcase
    end

    assign sleep_entry_d = (state_d == SleepSleep) && (state_q != SleepSleep);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SleepRun;
            idle_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            cause_q       <= '0;
            sleep_entry_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            cause_q       <= cause_d;
            sleep_entry_q <= sleep_entry_d;
        end
    end

    // Combinational wake term opens the gate in the same cycle a source fires.
    assign clock_en_o    = (state_q != SleepSleep) | wake_any;
    assign core_sleep_o  = ~clock_en_o;
    assign wake_cause_o  = cause_q;
    assign sleep_entry_o = sleep_entry_q;

`ifdef CVE2_SLEEP_STATS_EN
    logic [SleepStatsW-1:0] sleep_cycles_q;
    logic [15:0]            sleep_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sleep_cycles_q <= '0;
            sleep_count_q  <= '0;
        end else begin
            if ((state_q == SleepSleep) && (sleep_cycles_q != '1)) begin
                sleep_cycles_q <= sleep_cycles_q + SleepStatsW'(1);
            end
            if (sleep_entry_q && (sleep_count_q != '1)) begin
                sleep_count_q <= sleep_count_q + 16'd1;
            end
        end
    end

    assign sleep_cycles_o = sleep_cycles_q;
    assign sleep_count_o  = sleep_count_q;
`endif

    prim_clock_gating u_clk_gate (
        .clk_i     (clk_i),
        .en_i      (clock_en_o),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

endmodule
